// File: rtl/pio_arb_pkg.sv
// Shared types and helpers for the PIO write arbiter.
// Holds the FSM state encoding and the read-modify-write merge.
package pio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        ACK
    } state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    function automatic logic [31:0] merge_bits(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [31:0] mask
    );
        return (old & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request
// at or after the pointer (wrapping) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    int               w_j;
    logic [IDX_W-1:0] w_j_idx;

    // Walk from the farthest offset down so the nearest one is kept.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_j         = 0;
        w_j_idx     = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_j = int'(pointer) + off;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            w_j_idx = IDX_W'(w_j);
            if (req[w_j_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = w_j_idx;
            end
        end
    end

endmodule

// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter performing masked read-modify-write updates
// of a single-register Avalon-MM PIO on behalf of NUM_REQ requesters.
module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*DATA_W-1:0] req_mask,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [IDX_W-1:0]          last_owner,
    output logic [1:0]                pio_address,
    output logic                      pio_chipselect,
    output logic                      pio_write_n,
    output logic [31:0]               pio_writedata,
    input  logic [31:0]               pio_readdata
);

    state_t             r_state, w_state_nx;
    logic [IDX_W-1:0]   r_idx, w_idx_nx;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nx;
    logic [DATA_W-1:0]  r_data, w_data_nx;
    logic [DATA_W-1:0]  r_mask, w_mask_nx;
    logic [NUM_REQ-1:0] r_ack, w_ack_nx;
    logic               r_busy, w_busy_nx;
    logic [IDX_W-1:0]   r_owner, w_owner_nx;
    logic               r_cs, w_cs_nx;
    logic               r_wn, w_wn_nx;
    logic [31:0]        r_wd, w_wd_nx;
    logic [31:0]        w_merged;
    logic               w_grant_valid;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [DATA_W-1:0]  w_data_arr [NUM_REQ];
    logic [DATA_W-1:0]  w_mask_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_data_arr[g] = req_data[g*DATA_W +: DATA_W];
        assign w_mask_arr[g] = req_mask[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req         (req),
        .pointer     (r_ptr),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // Upper readdata bits are dropped before merging.
    assign w_merged = merge_bits(32'(pio_readdata[DATA_W-1:0]),
                                 32'(r_data), 32'(r_mask));

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_ptr_nx   = r_ptr;
        w_data_nx  = r_data;
        w_mask_nx  = r_mask;
        w_ack_nx   = '0;
        w_owner_nx = r_owner;
        w_cs_nx    = 1'b0;
        w_wn_nx    = 1'b1;
        w_wd_nx    = r_wd;
        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_nx = READ;
                    w_idx_nx   = w_grant_idx;
                    w_data_nx  = w_data_arr[w_grant_idx];
                    w_mask_nx  = w_mask_arr[w_grant_idx];
                    w_cs_nx    = 1'b1;
                end
            end
            READ: begin
                w_state_nx = WRITE;
                w_cs_nx    = 1'b1;
                w_wn_nx    = 1'b0;
                w_wd_nx    = w_merged;
            end
            WRITE: begin
                w_state_nx      = ACK;
                w_ack_nx[r_idx] = 1'b1;
                w_owner_nx      = r_idx;
                w_ptr_nx        = (r_idx == IDX_W'(NUM_REQ - 1)) ?
                                  '0 : r_idx + 1'b1;
            end
            ACK: begin
                w_state_nx = IDLE;
            end
        endcase
        w_busy_nx = (w_state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_data  <= '0;
            r_mask  <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_owner <= '0;
            r_cs    <= 1'b0;
            r_wn    <= 1'b1;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_ptr   <= w_ptr_nx;
            r_data  <= w_data_nx;
            r_mask  <= w_mask_nx;
            r_ack   <= w_ack_nx;
            r_busy  <= w_busy_nx;
            r_owner <= w_owner_nx;
            r_cs    <= w_cs_nx;
            r_wn    <= w_wn_nx;
            r_wd    <= w_wd_nx;
        end
    end

    assign ack            = r_ack;
    assign busy           = r_busy;
    assign last_owner     = r_owner;
    assign pio_address    = PIO_DATA_ADDR;
    assign pio_chipselect = r_cs;
    assign pio_write_n    = r_wn;
    assign pio_writedata  = r_wd;

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Scoreboard bench for pio_write_arbiter with a behavioural 4-bit PIO
// whose readdata carries junk in the unused upper bits.
module tb_pio_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [15:0] req_mask;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  last_owner;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic [3:0]  pio_q;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] exp_wr [$];
    int          exp_ack [$];

    pio_write_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_data       (req_data),
        .req_mask       (req_mask),
        .ack            (ack),
        .busy           (busy),
        .last_owner     (last_owner),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pio_q <= 4'h0;
        else if (pio_chipselect && !pio_write_n && pio_address == 2'd0)
            pio_q <= pio_writedata[3:0];
    end

    assign pio_readdata = {28'h5A5A5A5, pio_q};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    // Monitor: every PIO write and every ack must match the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pio_chipselect && !pio_write_n) begin
                if (exp_wr.size() == 0) miss("unexpected_write");
                else chk("pio_write", pio_writedata, exp_wr.pop_front());
            end
            if (ack != 4'b0) begin
                if (exp_ack.size() == 0) begin
                    miss("unexpected_ack");
                end else begin
                    int e;
                    e = exp_ack.pop_front();
                    chk("ack_onehot", 32'(ack), 32'(1) << e);
                    chk("last_owner", 32'(last_owner), 32'(e));
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] d,
                           input logic [3:0] m);
        req_data[i*4 +: 4] = d;
        req_mask[i*4 +: 4] = m;
    endtask

    task automatic wait_ack(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0 && n < 12);
        if (ack == 4'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no ack expected ack within 12 cycles", nm);
        end
    endtask

    task automatic do_req(input int i, input logic [3:0] d,
                          input logic [3:0] m, input logic [3:0] exp_q);
        set_req(i, d, m);
        exp_wr.push_back(32'(exp_q));
        exp_ack.push_back(i);
        req[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 4'b0;
        wait_ack("do_req_ack");
        @(negedge clk);
        chk("pio_after_req", 32'(pio_q), 32'(exp_q));
    endtask

    initial begin
        int t_prev;
        logic seen;
        reset_n  = 1'b0;
        req      = 4'b0;
        req_data = 16'h0;
        req_mask = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(last_owner), 32'h0);
        chk("rst_cs", 32'(pio_chipselect), 32'h0);
        chk("rst_wn", 32'(pio_write_n), 32'h1);
        chk("rst_addr", 32'(pio_address), 32'h0);
        chk("rst_wd", pio_writedata, 32'h0);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (pio_chipselect) seen = 1'b1;
        end
        chk("idle_cs", 32'(seen), 32'h0);

        // Single request, cycle-by-cycle.
        set_req(2, 4'b1010, 4'b1111);
        exp_wr.push_back(32'h0000000A);
        exp_ack.push_back(2);
        req = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        req = 4'b0;
        chk("read_busy", 32'(busy), 32'h1);
        chk("read_cs", 32'(pio_chipselect), 32'h1);
        chk("read_wn", 32'(pio_write_n), 32'h1);
        chk("read_addr", 32'(pio_address), 32'h0);
        @(negedge clk);
        chk("write_cs", 32'(pio_chipselect), 32'h1);
        chk("write_wn", 32'(pio_write_n), 32'h0);
        chk("write_wd", pio_writedata, 32'h0000000A);
        @(negedge clk);
        chk("ack_vec", 32'(ack), 32'h4);
        chk("ack_owner", 32'(last_owner), 32'h2);
        chk("ack_cs", 32'(pio_chipselect), 32'h0);
        chk("ack_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("pio_single", 32'(pio_q), 32'hA);

        // Masked merges.
        do_req(3, 4'b1100, 4'b1111, 4'hC);
        do_req(1, 4'b0011, 4'b0011, 4'hF);
        do_req(0, 4'b0000, 4'b1000, 4'h7);

        // Contention from reset: order 0,1,2,3,0.
        reset_n = 1'b0;
        set_req(0, 4'b0001, 4'b0011);
        set_req(1, 4'b0110, 4'b0110);
        set_req(2, 4'b1000, 4'b1100);
        set_req(3, 4'b0000, 4'b0001);
        req = 4'b1111;
        foreach (exp_wr[i]) chk("queue_pre", 32'h1, 32'h0);
        exp_wr  = {32'h1, 32'h7, 32'hB, 32'hA, 32'h9};
        exp_ack = {0, 1, 2, 3, 0};
        @(negedge clk);
        reset_n = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ack("contention_ack");
            if (k > 0) chk("ack_spacing", 32'(cyc - t_prev), 32'd4);
            t_prev = cyc;
            if (k == 3) begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                req = 4'b0;
            end
        end
        @(negedge clk);
        chk("pio_contention", 32'(pio_q), 32'h9);

        // Early drop after grant, then drop before grant.
        do_req(3, 4'b0110, 4'b0110, 4'hF);
        set_req(1, 4'b0000, 4'b0011);
        set_req(2, 4'b1111, 4'b1111);
        exp_wr.push_back(32'hC);
        exp_ack.push_back(1);
        req = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        wait_ack("drop_ack");
        repeat (8) @(negedge clk);
        chk("pio_drop", 32'(pio_q), 32'hC);
        chk("drop_busy", 32'(busy), 32'h0);

        // Reset during WRITE.
        set_req(0, 4'b1111, 4'b1111);
        req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_cs", 32'(pio_chipselect), 32'h0);
        chk("mid_wn", 32'(pio_write_n), 32'h1);
        chk("mid_ack", 32'(ack), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_wd", pio_writedata, 32'h0);
        req = 4'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_pio", 32'(pio_q), 32'h0);

        // Pointer back at 0: req1 beats req3.
        set_req(1, 4'b0101, 4'b1111);
        set_req(3, 4'b0010, 4'b0010);
        exp_wr.push_back(32'h5);
        exp_wr.push_back(32'h7);
        exp_ack.push_back(1);
        exp_ack.push_back(3);
        req = 4'b1010;
        wait_ack("ptr_ack1");
        req = 4'b1000;
        wait_ack("ptr_ack3");
        req = 4'b0000;
        @(negedge clk);
        chk("pio_ptr", 32'(pio_q), 32'h7);
        chk("owner_final", 32'(last_owner), 32'h3);

        repeat (6) @(negedge clk);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'h0);
        chk("ack_queue_empty", 32'(exp_ack.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pio_write_arbiter.md
Name: pio_write_arbiter

Overview:
- Shares one single-register output PIO (4-bit Avalon-MM slave: address, chipselect, write_n, writedata, readdata) between NUM_REQ hardware requesters.
- Each requester asks for a masked update of the port bits. The arbiter grants round-robin and performs a read-modify-write on PIO address 0, so requesters owning disjoint bits never clobber each other.
- Sits between the hardware sequencers and the PIO slave port; the PIO's own out_port still drives the pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, PIO data width; the low DATA_W bits of the 32-bit bus are used.
- IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester update request, level; hold until ack.
- req_data  in  NUM_REQ*DATA_W  new bit values; requester i uses slice [i*DATA_W +: DATA_W].
- req_mask  in  NUM_REQ*DATA_W  bit enables; 1 = take bit from req_data, 0 = keep current PIO bit.
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- busy  out  1  high whenever the FSM is not IDLE.
- last_owner  out  IDX_W  index of the most recently serviced requester.
- pio_address  out  2  PIO register address; always 0.
- pio_chipselect  out  1  PIO chipselect.
- pio_write_n  out  1  PIO write strobe, active low.
- pio_writedata  out  32  PIO write data, zero-extended from DATA_W.
- pio_readdata  in  32  PIO readdata; combinational, zero wait states.

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - state=IDLE, ack=0, busy=0, last_owner=0, rr pointer=0 (requester 0 highest priority).
  - pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
- All outputs are registered.
- FSM states IDLE -> READ -> WRITE -> ACK -> IDLE.
- IDLE:
  - If any req bit is high at edge N, pick the winner by round-robin.
  - Latch the winner index, req_data slice and req_mask slice.
  - Go to READ, with busy=1 from N+1.
- READ (cycle N+1):
  - pio_chipselect=1, pio_write_n=1, pio_address=0.
  - At the end of the cycle, sample old = pio_readdata[DATA_W-1:0].
- WRITE (cycle N+2):
  - pio_chipselect=1, pio_write_n=0.
  - pio_writedata = zero-extend((old & ~mask) | (data & mask)).
- ACK (cycle N+3):
  - chipselect=0, write_n=1, ack[winner]=1 for exactly one cycle.
  - last_owner=winner; the rr pointer moves to winner+1, wrapping mod NUM_REQ.
- Next IDLE (cycle N+4) may accept a new request in the same cycle.
- Timing: latency from req to ack is 3 cycles; peak throughput is one update per 4 cycles.
- Round-robin: search starts at the pointer, increasing index, wrapping; the first asserted req wins.
  - Simultaneous requests are serviced in pointer order.
  - No requester waits more than NUM_REQ-1 services.
- Request hold rule: req, req_data and req_mask are sampled only at the IDLE grant edge.
  - If req is dropped after the grant, the write still completes and ack still pulses.
  - If req is dropped before the grant, the request is never serviced.
  - If the requester holds req high through ack, it is treated as a new request at the next IDLE but loses priority to others.
- A mask of all zeros still performs READ and WRITE; the PIO value is unchanged and ack is given.
- A mask of all ones still performs READ; timing is uniform.
- Bits of pio_readdata above DATA_W are ignored. pio_writedata bits above DATA_W are always 0.
- Reset mid-operation: the FSM aborts immediately to the reset values, no ack is issued, and any in-flight write is lost. The PIO shares reset_n and returns to 0 as well.
- The PIO must have no other writer while busy=1; the integration enforces this.

Decomposition:
- Package pio_arb_pkg holds:
  - state enum {IDLE, READ, WRITE, ACK};
  - PIO_DATA_ADDR = 2'd0;
  - a function merge_bits(old, data, mask).
- One natural sub-module, rr_arbiter, is a combinational round-robin picker.
  - Inputs: req, pointer.
  - Outputs: grant_valid, grant_idx.
- The FSM and datapath live in the top module.

Test Plan:
- Reset: hold reset_n=0 -> all outputs at their reset values. Release, no req -> pio_chipselect stays 0 indefinitely.
- Single request: PIO=0, req[2] with data=4'b1010, mask=4'b1111 -> READ at N+1, WRITE of 32'h0000000A at N+2, ack[2] at N+3. PIO out reads 4'hA afterwards; last_owner=2.
- Masked merge: PIO=4'b1100, req[1] with data=4'b0011, mask=4'b0011 -> write 32'h0000000F. Then req[0] with data=0, mask=4'b1000 -> write 32'h00000007.
- Contention fairness: req=4'b1111 held from reset -> acks in order 0,1,2,3,0, each 4 cycles apart. Final PIO value equals the last merged write.
- Early drop: assert req[3] for one IDLE cycle, then drop -> write completes, ack[3] pulses. A req dropped before its grant (while another requester is busy) -> never acked.
- Reset mid-operation: pulse reset_n low during WRITE -> no ack, chipselect=0 immediately, pointer=0. The PIO reads 0 after release.
